// File: rtl/flood_fill.sv
// Minesweeper flood-fill engine: grows a reveal region from a seed tile
// across zero-adjacency tiles and emits the final mask with a one-cycle apply.
module flood_fill #(
  parameter int GRID_SIZE   = 8,
  parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
  parameter int INDEX_BITS  = $clog2(TOTAL_TILES),
  parameter int ITER_BITS   = $clog2(TOTAL_TILES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INDEX_BITS-1:0]  start_index,
  input  logic [TOTAL_TILES-1:0] mine_map,
  input  logic [TOTAL_TILES-1:0] zero_map,
  input  logic [TOTAL_TILES-1:0] flagged,
  output logic [TOTAL_TILES-1:0] flood_update,
  output logic                   flood_apply,
  output logic                   busy,
  output logic                   done,
  output logic [ITER_BITS-1:0]   iter_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    APPLY
  } state_t;

  state_t                 state, state_next;
  logic [TOTAL_TILES-1:0] mask, mask_next;
  logic [TOTAL_TILES-1:0] upd_next;
  logic [ITER_BITS-1:0]   iter_next;
  logic [TOTAL_TILES-1:0] src, grow, grown;
  logic [ITER_BITS-1:0]   iter_inc;
  logic [31:0]            seed_wide;
  logic                   seed_bad;

  assign seed_wide = 32'(start_index);
  assign seed_bad  = (seed_wide >= 32'(TOTAL_TILES))
                   || mine_map[start_index]
                   || flagged[start_index];

  // Bounds are checked on row/col separately so no neighbour wraps rows.
  always_comb begin
    grow = '0;
    src  = mask & zero_map;
    for (int r = 0; r < GRID_SIZE; r++) begin
      for (int c = 0; c < GRID_SIZE; c++) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0)
                && r + dr >= 0 && r + dr < GRID_SIZE
                && c + dc >= 0 && c + dc < GRID_SIZE
                && src[(r + dr) * GRID_SIZE + (c + dc)])
              grow[r * GRID_SIZE + c] = 1'b1;
          end
        end
      end
    end
  end

  assign grown    = (mask | grow) & ~mine_map & ~flagged;
  assign iter_inc = iter_count + ITER_BITS'(1);

  always_comb begin
    state_next = state;
    mask_next  = mask;
    upd_next   = flood_update;
    iter_next  = iter_count;
    unique case (state)
      IDLE: begin
        if (start) begin
          iter_next = '0;
          upd_next  = '0;
          if (seed_bad) begin
            mask_next  = '0;
            state_next = APPLY;
          end else begin
            mask_next  = '0;
            mask_next[start_index] = 1'b1;
            state_next = EXPAND;
          end
        end
      end
      EXPAND: begin
        iter_next = iter_inc;
        if (grown == mask
            || iter_inc == ITER_BITS'(TOTAL_TILES - 1)) begin
          upd_next   = mask;
          state_next = APPLY;
        end else begin
          mask_next = grown;
        end
      end
      APPLY: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mask         <= '0;
      flood_update <= '0;
      iter_count   <= '0;
    end else begin
      state        <= state_next;
      mask         <= mask_next;
      flood_update <= upd_next;
      iter_count   <= iter_next;
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == APPLY);
  assign flood_apply = (state == APPLY) && (|mask);

endmodule

// File: tb/tb_flood_fill.sv
// Directed bench for flood_fill: latency, masks, rejects, edges, abort.
module tb_flood_fill;

  localparam int G = 8;
  localparam int N = G * G;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    start_index;
  logic [N-1:0]  mine_map;
  logic [N-1:0]  zero_map;
  logic [N-1:0]  flagged;
  logic [N-1:0]  flood_update;
  logic          flood_apply;
  logic          busy;
  logic          done;
  logic [6:0]    iter_count;

  int checks = 0;
  int errors = 0;

  flood_fill #(.GRID_SIZE(G)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_index(start_index),
    .mine_map(mine_map),
    .zero_map(zero_map),
    .flagged(flagged),
    .flood_update(flood_update),
    .flood_apply(flood_apply),
    .busy(busy),
    .done(done),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a request and checks the cycle done arrives plus the result.
  // poke_cyc > 0 pulses start again at that cycle while busy.
  task automatic req(input string tag, input int seed,
                     input logic [63:0] exp_mask,
                     input int exp_cyc, input int exp_iter,
                     input int poke_cyc);
    int cyc;
    logic [5:0] s;
    s = 6'(seed);
    tick();
    start = 1'b1;
    start_index = s;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == poke_cyc) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, ".cyc"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".apply"}, 64'(flood_apply), 64'(exp_mask != 0));
    check({tag, ".mask"}, flood_update, exp_mask);
    check({tag, ".iter"}, 64'(iter_count), 64'(exp_iter));
    tick();
    check({tag, ".idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, ".hold"}, flood_update, exp_mask);
  endtask

  initial begin
    logic [63:0] col3;
    int seen;
    rst = 1'b1;
    start = 1'b0;
    start_index = '0;
    mine_map = '0;
    zero_map = '1;
    flagged = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.outs", {60'd0, busy, done, flood_apply, 1'b0}, 64'd0);
    check("rst.mask", flood_update, 64'd0);
    check("rst.iter", 64'(iter_count), 64'd0);

    req("full", 0, {64{1'b1}}, 9, 8, 0);

    zero_map = '1;
    zero_map[27] = 1'b0;
    req("nz27", 27, 64'h1 << 27, 2, 1, 0);

    zero_map = '1;
    mine_map = 64'h1 << 5;
    req("mine", 5, 64'd0, 1, 0, 0);
    mine_map = '0;
    flagged = 64'h1 << 5;
    req("flag", 5, 64'd0, 1, 0, 0);
    flagged = '0;

    zero_map = 64'h1 << 7;
    req("east", 7, 64'h0000_0000_0000_C0C0, 3, 2, 0);
    check("east.bit8", 64'(flood_update[8]), 64'd0);

    zero_map = 64'h1 << 8;
    req("west", 8, 64'h0000_0000_0003_0303, 3, 2, 0);
    check("west.bit7", 64'(flood_update[7]), 64'd0);

    col3 = 64'h0808_0808_0808_0808;
    mine_map = col3;
    zero_map = ~col3;
    req("barrier", 0, 64'h0707_0707_0707_0707, 9, 8, 0);
    mine_map = '0;
    zero_map = '1;

    req("poke", 0, {64{1'b1}}, 9, 8, 3);

    tick();
    start = 1'b1;
    start_index = 6'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort.busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.outs", {61'd0, busy, done, flood_apply}, 64'd0);
    check("abort.mask", flood_update, 64'd0);
    check("abort.iter", 64'(iter_count), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (flood_apply || done || busy) seen++;
      tick();
    end
    check("abort.quiet", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flood_fill.md
Name: flood_fill

Overview:
- Flood-fill engine for the minesweeper board; the producer of the flood_update/flood_apply interface consumed by the tile-state register block.
- On a reveal request it grows a region from the cursor tile across zero-adjacency tiles, including their border tiles.
- When the region stops growing, it presents the final mask for one clock with a flood_apply pulse.
- Expansion is wavefront-parallel: each cycle every member zero tile annexes its 8 neighbours.

Parameters:
- GRID_SIZE, 8, board edge length in tiles (square board, row-major, index = row*GRID_SIZE+col).
- TOTAL_TILES, GRID_SIZE*GRID_SIZE, tile count.
- INDEX_BITS, $clog2(TOTAL_TILES), tile index width.
- ITER_BITS, $clog2(TOTAL_TILES+1), iteration counter width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- start_index  in  INDEX_BITS  seed tile.
- mine_map  in  TOTAL_TILES  1 = tile holds mine.
- zero_map  in  TOTAL_TILES  1 = tile has zero adjacent mines.
- flagged  in  TOTAL_TILES  current flag state.
- flood_update  out  TOTAL_TILES  registered region mask.
- flood_apply  out  1  one-cycle pulse, flood_update valid.
- busy  out  1  high in EXPAND and APPLY.
- done  out  1  one-cycle pulse ending every accepted request.
- iter_count  out  ITER_BITS  EXPAND cycles used by the last or current request.

Behaviour:
- One clock. Reset is synchronous and active-high on rst.
- Reset state: IDLE, with mask, flood_update, iter_count all 0 and flood_apply, busy, done all 0.
- rst high at any time, including mid-EXPAND/APPLY, aborts immediately; no apply pulse is issued.
- IDLE:
  - When start=1, clear iter_count and evaluate the seed.
  - If start_index >= TOTAL_TILES, or mine_map[start_index], or flagged[start_index]: mask <= 0, go to APPLY (reject).
  - Otherwise mask <= one-hot(start_index), go to EXPAND.
- EXPAND, one cycle per step:
  - grow = 8-neighbour dilation of (mask & zero_map).
  - next = (mask | grow) & ~mine_map & ~flagged.
  - iter_count increments each cycle.
  - If next == mask or iter_count reaches TOTAL_TILES-1: go to APPLY, mask unchanged.
  - Else mask <= next.
- Dilation edge rule: no wrap-around.
  - Column 0 tiles have no west-side neighbours; column GRID_SIZE-1 tiles have no east-side neighbours.
  - Rows 0 and GRID_SIZE-1 have no north and south neighbours respectively.
  - Index arithmetic must never carry into an adjacent row.
- APPLY, exactly one cycle:
  - flood_update is driven from mask.
  - flood_apply = 1 iff mask != 0.
  - done = 1.
  - Next state is IDLE.
- flood_update holds its last value in IDLE; it is cleared when the next start is accepted.
- start while busy is ignored and not queued.
- start in the same cycle as the APPLY exit is ignored; start is first accepted in the following IDLE cycle.
- mine_map, zero_map and flagged must be stable while busy (caller obligation); they are read combinationally every EXPAND cycle.
- Latency, with start sampled in cycle 0:
  - Non-zero seed: EXPAND cycle 1, APPLY cycle 2.
  - Region of Chebyshev radius R: APPLY at cycle R+2.
  - Rejects: APPLY/done at cycle 1.
- Mines are never set in flood_update. A revealed tile may appear in the mask; this is harmless because the consumer ORs the mask in.

Test Plan:
- 8x8 board, no mines, all zero_map=1, start_index=0 → flood_apply at cycle 9; flood_update = all ones; iter_count = 8; done with flood_apply.
- Seed 27 with zero_map[27]=0 → flood_update = only bit 27; flood_apply at cycle 2; iter_count = 1.
- Seed with mine_map[seed]=1, and separately flagged[seed]=1 → done at cycle 1; flood_apply stays 0; flood_update = 0.
- Wrap check: single zero tile at index 7 (row 0, col 7), all else non-zero, no mines → mask = {6,7,14,15} only; bit 8 must be 0.
- Barrier: a column of mines at col 3, all other tiles zero, seed 0 → mask = cols 0-2 of every row, plus no col 3 or higher bits.
- rst=1 during EXPAND, and start pulsed while busy → after rst: IDLE, outputs 0, no flood_apply. Start while busy is ignored; busy/done timing is unchanged from the original request.
